adc_scan_sched: RTL and testbench

- Sequences conversions on the shared 12-bit SPI ADC frame engine.
- Runs a periodic round-robin scan over a channel mask. Also accepts one-shot conversion requests, which have priority over the scan.
- Issues one conversion at a time, with a watchdog, and publishes each result on a single-cycle result strobe for the channel-sample register bank.

---
 rtl/adc_scan_sched.sv | 170 +++++++++++++++++
 tb/tb_adc_scan_sched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sched.sv
// Conversion scheduler for the shared SPI ADC frame engine: periodic round-robin
// scan over a channel mask, one-shot requests with priority, watchdog-guarded WAIT.
module adc_scan_sched #(
   parameter int NUM_CH      = 7,
   parameter int CH_W        = 3,
   parameter int DATA_W      = 12,
   parameter int SCAN_PERIOD = 256,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              c1m,
   input  logic              rst_n,
   input  logic              scan_en,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              req_valid,
   input  logic [CH_W-1:0]   req_ch,
   output logic              req_ready,
   output logic              conv_start,
   output logic [CH_W-1:0]   conv_ch,
   input  logic              conv_busy,
   input  logic              conv_done,
   input  logic [DATA_W-1:0] conv_data,
   output logic              res_valid,
   output logic [CH_W-1:0]   res_ch,
   output logic [DATA_W-1:0] res_data,
   output logic              res_oneshot,
   output logic              scan_overrun,
   output logic              timeout_err,
   input  logic              err_clr,
   output logic [1:0]        dbg_state
);

   localparam int CNT_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
   localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_PERIOD - 1);
   localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

   // Handshake: a one-shot is taken on any edge where req_valid && req_ready;
   // req_ready is simply "holding register empty", independent of req_valid.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  period_cnt;
   logic              scan_en_d;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] pending_left;
   logic [NUM_CH-1:0] clr_mask;
   logic [CH_W-1:0]   hold;
   logic              hold_valid;
   logic              oneshot_f;
   logic [WD_W-1:0]   watchdog;
   logic [CH_W-1:0]   low_ch;
   logic              period_wrap;
   logic              reload;
   logic              wait_end;

   assign req_ready   = !hold_valid;
   assign dbg_state   = state;
   assign period_wrap = (period_cnt == CNT_LAST);
   assign reload      = period_wrap || !scan_en_d;
   assign wait_end    = (state == WAIT) && (conv_done || (watchdog == WD_LIMIT));

   // Lowest set bit wins, so scan walks the mask upward from channel 0.
   always_comb begin
      low_ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (pending[i]) low_ch = CH_W'(i);
      end
   end

   always_comb begin
      clr_mask = '0;
      if (wait_end && !oneshot_f) clr_mask = NUM_CH'(1) << conv_ch;
   end

   assign pending_left = pending & ~clr_mask;

   // Round timer and pending set; completion clears land before any reload.
   always_ff @(posedge c1m or negedge rst_n) begin
      if (!rst_n) begin
         period_cnt   <= '0;
         scan_en_d    <= 1'b0;
         pending      <= '0;
         scan_overrun <= 1'b0;
      end else begin
         scan_en_d <= scan_en;
         if (err_clr) scan_overrun <= 1'b0;
         if (!scan_en) begin
            period_cnt <= '0;
            pending    <= '0;
         end else begin
            period_cnt <= period_wrap ? '0 : period_cnt + CNT_W'(1);
            if (reload && (pending_left == '0)) begin
               pending <= ch_mask;
            end else begin
               pending <= pending_left;
               if (reload) scan_overrun <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge c1m or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         conv_start  <= 1'b0;
         conv_ch     <= '0;
         oneshot_f   <= 1'b0;
         watchdog    <= '0;
         res_valid   <= 1'b0;
         res_ch      <= '0;
         res_data    <= '0;
         res_oneshot <= 1'b0;
         timeout_err <= 1'b0;
         hold        <= '0;
         hold_valid  <= 1'b0;
      end else begin
         conv_start <= 1'b0;
         res_valid  <= 1'b0;
         if (err_clr) timeout_err <= 1'b0;
         // Out-of-range channels are swallowed: accepted but never held.
         if (req_valid && req_ready && ({1'b0, req_ch} < NUM_CH_L)) begin
            hold       <= req_ch;
            hold_valid <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (!conv_busy) begin
                  if (hold_valid) begin
                     conv_ch    <= hold;
                     oneshot_f  <= 1'b1;
                     hold_valid <= 1'b0;
                     conv_start <= 1'b1;
                     state      <= ISSUE;
                  end else if (pending != '0) begin
                     conv_ch    <= low_ch;
                     oneshot_f  <= 1'b0;
                     conv_start <= 1'b1;
                     state      <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               watchdog <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (conv_done) begin
                  res_valid   <= 1'b1;
                  res_ch      <= conv_ch;
                  res_data    <= conv_data;
                  res_oneshot <= oneshot_f;
                  state       <= IDLE;
               end else if (watchdog == WD_LIMIT) begin
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end else begin
                  watchdog <= watchdog + WD_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_scan_sched.sv
// Directed bench for adc_scan_sched: engine model, start/result scoreboard,
// and a second instance with a short scan period for the overrun cases.
`timescale 1ns/1ps
module tb_adc_scan_sched;
   localparam int NUM_CH = 7;
   localparam int CH_W   = 3;
   localparam int DATA_W = 12;

   logic c1m = 1'b0;
   logic rst_n = 1'b0;
   always #5 c1m = ~c1m;

   logic              scan_en = 1'b0, req_valid = 1'b0, err_clr = 1'b0;
   logic [NUM_CH-1:0] ch_mask = '0;
   logic [CH_W-1:0]   req_ch = '0;
   logic              conv_busy = 1'b0, conv_done = 1'b0;
   logic [DATA_W-1:0] conv_data = '0;
   logic              req_ready, conv_start, res_valid, res_oneshot, scan_overrun, timeout_err;
   logic [CH_W-1:0]   conv_ch, res_ch;
   logic [DATA_W-1:0] res_data;
   logic [1:0]        dbg_state;

   logic              f_scan_en = 1'b0, f_err_clr = 1'b0;
   logic [NUM_CH-1:0] f_mask = '0;
   logic              f_busy = 1'b0, f_done = 1'b0;
   logic [DATA_W-1:0] f_data = '0;
   logic              f_req_ready, f_start, f_res_valid, f_res_oneshot, f_overrun, f_timeout;
   logic [CH_W-1:0]   f_conv_ch, f_res_ch;
   logic [DATA_W-1:0] f_res_data;
   logic [1:0]        f_dbg_state;

   adc_scan_sched u_dut (
      .c1m(c1m), .rst_n(rst_n), .scan_en(scan_en), .ch_mask(ch_mask),
      .req_valid(req_valid), .req_ch(req_ch), .req_ready(req_ready),
      .conv_start(conv_start), .conv_ch(conv_ch), .conv_busy(conv_busy),
      .conv_done(conv_done), .conv_data(conv_data), .res_valid(res_valid),
      .res_ch(res_ch), .res_data(res_data), .res_oneshot(res_oneshot),
      .scan_overrun(scan_overrun), .timeout_err(timeout_err), .err_clr(err_clr),
      .dbg_state(dbg_state)
   );

   adc_scan_sched #(.SCAN_PERIOD(16)) u_fast (
      .c1m(c1m), .rst_n(rst_n), .scan_en(f_scan_en), .ch_mask(f_mask),
      .req_valid(1'b0), .req_ch(3'd0), .req_ready(f_req_ready),
      .conv_start(f_start), .conv_ch(f_conv_ch), .conv_busy(f_busy),
      .conv_done(f_done), .conv_data(f_data), .res_valid(f_res_valid),
      .res_ch(f_res_ch), .res_data(f_res_data), .res_oneshot(f_res_oneshot),
      .scan_overrun(f_overrun), .timeout_err(f_timeout), .err_clr(f_err_clr),
      .dbg_state(f_dbg_state)
   );

   int checks = 0;
   int errors = 0;
   logic [15:0]     exp_q[$];        // {oneshot, ch, data}
   logic [CH_W-1:0] exp_start_q[$];
   logic [15:0]     mon_e;

   int eng_lat = 20;
   bit eng_hang = 1'b0;
   int eng_cnt = 0;
   int f_cnt = 0;

   function automatic logic [DATA_W-1:0] data_of(input logic [CH_W-1:0] ch);
      return 12'h3C0 + {9'd0, ch} * 12'h011;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push_res(input logic oneshot, input logic [CH_W-1:0] ch);
      exp_q.push_back({oneshot, ch, data_of(ch)});
   endtask

   task automatic wait_start(input int budget);
      int n = 0;
      do begin
         @(negedge c1m);
         n++;
      end while (!conv_start && n < budget);
      check("start_wait", 32'(conv_start), 32'd1);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((exp_q.size() + exp_start_q.size()) != 0 && n < budget) begin
         @(negedge c1m);
         n++;
      end
      check("drain", 32'(exp_q.size() + exp_start_q.size()), 32'd0);
   endtask

   // Frame engine models: busy for eng_lat cycles after a start, done on the last.
   always @(negedge c1m) begin
      conv_done = 1'b0;
      if (eng_cnt > 0) begin
         eng_cnt--;
         if (eng_cnt == 0) begin
            if (eng_hang) eng_hang = 1'b0;
            else begin
               conv_done = 1'b1;
               conv_data = data_of(conv_ch);
            end
         end
      end
      if (conv_start) eng_cnt = eng_lat;
      conv_busy = (eng_cnt > 0);
   end

   always @(negedge c1m) begin
      f_done = 1'b0;
      if (f_cnt > 0) begin
         f_cnt--;
         if (f_cnt == 0) begin
            f_done = 1'b1;
            f_data = data_of(f_conv_ch);
         end
      end
      if (f_start) f_cnt = 20;
      f_busy = (f_cnt > 0);
   end

   always @(negedge c1m) begin
      if (rst_n) begin
         if (conv_start) begin
            if (exp_start_q.size() == 0) check("unexp_start", 32'(conv_ch), 32'hFF);
            else check("start_ch", 32'(conv_ch), 32'(exp_start_q.pop_front()));
         end
         if (res_valid) begin
            if (exp_q.size() == 0) check("unexp_res", 32'(res_ch), 32'hFF);
            else begin
               mon_e = exp_q.pop_front();
               check("res_ch", 32'(res_ch), 32'(mon_e[14:12]));
               check("res_data", 32'(res_data), 32'(mon_e[11:0]));
               check("res_oneshot", 32'(res_oneshot), 32'(mon_e[15]));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      bit low_ok;
      int n;
      // Reset values
      repeat (2) @(negedge c1m);
      check("rst_conv_start", 32'(conv_start), 32'd0);
      check("rst_conv_ch", 32'(conv_ch), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_data", 32'(res_data), 32'd0);
      check("rst_overrun", 32'(scan_overrun), 32'd0);
      check("rst_timeout", 32'(timeout_err), 32'd0);
      rst_n = 1'b1;
      @(negedge c1m);
      check("rst_req_ready", 32'(req_ready), 32'd1);

      // Two scan rounds over channels 0 and 2
      eng_lat = 20;
      for (int r = 0; r < 2; r++) begin
         exp_start_q.push_back(3'd0); exp_start_q.push_back(3'd2);
         push_res(1'b0, 3'd0); push_res(1'b0, 3'd2);
      end
      ch_mask = 7'b0000101;
      scan_en = 1'b1;
      wait_drain(800);
      check("scan_no_overrun", 32'(scan_overrun), 32'd0);
      scan_en = 1'b0;
      repeat (3) @(negedge c1m);

      // One-shot arriving while channel 0 is converting
      exp_start_q.push_back(3'd0); exp_start_q.push_back(3'd5); exp_start_q.push_back(3'd2);
      push_res(1'b0, 3'd0); push_res(1'b1, 3'd5); push_res(1'b0, 3'd2);
      scan_en = 1'b1;
      wait_start(20);
      @(negedge c1m);
      check("rdy_before_req", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_ch = 3'd5;
      @(negedge c1m);
      req_valid = 1'b0;
      check("rdy_after_acc", 32'(req_ready), 32'd0);
      low_ok = 1'b1;
      n = 0;
      while (!conv_start && n < 100) begin
         if (req_ready) low_ok = 1'b0;
         @(negedge c1m);
         n++;
      end
      check("rdy_low_until_issue", 32'(low_ok), 32'd1);
      check("os_start_seen", 32'(conv_start), 32'd1);
      check("rdy_at_issue", 32'(req_ready), 32'd1);
      wait_drain(200);
      scan_en = 1'b0;
      repeat (3) @(negedge c1m);

      // Overrun on the 16-cycle instance, err_clr, and err_clr against a new set
      f_mask = 7'h7F;
      f_scan_en = 1'b1;
      repeat (15) @(negedge c1m);
      check("ovr_before_wrap", 32'(f_overrun), 32'd0);
      @(negedge c1m);
      check("ovr_first_wrap", 32'(f_overrun), 32'd1);
      f_err_clr = 1'b1;
      @(negedge c1m);
      f_err_clr = 1'b0;
      check("ovr_cleared", 32'(f_overrun), 32'd0);
      repeat (14) @(negedge c1m);
      check("ovr_before_wrap2", 32'(f_overrun), 32'd0);
      @(negedge c1m);
      check("ovr_second_wrap", 32'(f_overrun), 32'd1);
      repeat (15) @(negedge c1m);
      f_err_clr = 1'b1;
      @(negedge c1m);
      f_err_clr = 1'b0;
      check("ovr_set_beats_clr", 32'(f_overrun), 32'd1);
      f_scan_en = 1'b0;

      // Watchdog: channel 1 never completes, channel 3 follows
      eng_hang = 1'b1;
      exp_start_q.push_back(3'd1); exp_start_q.push_back(3'd3);
      push_res(1'b0, 3'd3);
      ch_mask = 7'b0001010;
      scan_en = 1'b1;
      wait_start(20);
      n = 0;
      @(negedge c1m);
      while (!timeout_err && n < 200) begin
         n++;
         @(negedge c1m);
      end
      check("timeout_cycles", 32'(n), 32'd64);
      wait_drain(200);
      check("timeout_sticky", 32'(timeout_err), 32'd1);
      scan_en = 1'b0;
      repeat (3) @(negedge c1m);

      // Reset in WAIT, then the scan restarts from the lowest mask bit
      exp_start_q.push_back(3'd1);
      ch_mask = 7'b0000110;
      scan_en = 1'b1;
      wait_start(20);
      repeat (5) @(negedge c1m);
      rst_n = 1'b0;
      #1;
      check("arst_conv_ch", 32'(conv_ch), 32'd0);
      check("arst_conv_start", 32'(conv_start), 32'd0);
      check("arst_res_valid", 32'(res_valid), 32'd0);
      check("arst_timeout", 32'(timeout_err), 32'd0);
      check("arst_overrun", 32'(scan_overrun), 32'd0);
      exp_start_q.push_back(3'd1); exp_start_q.push_back(3'd2);
      push_res(1'b0, 3'd1); push_res(1'b0, 3'd2);
      repeat (2) @(negedge c1m);
      rst_n = 1'b1;
      wait_drain(200);
      scan_en = 1'b0;
      repeat (3) @(negedge c1m);

      // One-shot latency; done on the watchdog-limit cycle is a normal completion
      eng_lat = 64;
      exp_start_q.push_back(3'd4);
      push_res(1'b1, 3'd4);
      req_valid = 1'b1; req_ch = 3'd4;
      @(negedge c1m);
      req_valid = 1'b0;
      check("os_lat_ready", 32'(req_ready), 32'd0);
      check("os_lat_nostart", 32'(conv_start), 32'd0);
      @(negedge c1m);
      check("os_lat_start", 32'(conv_start), 32'd1);
      wait_drain(200);
      check("limit_done_no_err", 32'(timeout_err), 32'd0);

      // Out-of-range one-shot is swallowed
      req_valid = 1'b1; req_ch = 3'd7;
      @(negedge c1m);
      req_valid = 1'b0;
      check("inv_ready", 32'(req_ready), 32'd1);
      repeat (10) @(negedge c1m);
      check("inv_ready_later", 32'(req_ready), 32'd1);
      check("inv_no_start", 32'(conv_start), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
